pm_line_cache: RTL and testbench
================================

Name: pm_line_cache

Overview:
Direct-mapped instruction line cache between the micro's program-memory fetch port and the slow program memory. It serves the instruction at pm_address when the line is cached. On a miss it raises hold to stall the core, then fills the whole line from program memory over a valid handshake. It drives the core's hold, start_hold, end_hold and hold_count observation signals.

Parameters:
ADDR_W, 8, program address width
DATA_W, 8, instruction word width
LINE_WORDS, 4, words per line (power of 2, >=2)
NUM_LINES, 4, lines in cache (power of 2, >=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
pm_address  in  ADDR_W  fetch address from core
pm_data  out  DATA_W  instruction to core; valid when hold=0
hold  out  1  core stall request
start_hold  out  1  one-cycle pulse on miss detection
end_hold  out  1  one-cycle pulse on last fill word
hold_count  out  3  words written in current fill
mem_addr  out  ADDR_W  program memory read address
mem_rd  out  1  program memory read request
mem_data  in  DATA_W  program memory read data
mem_valid  in  1  mem_data valid for mem_addr this cycle

Behaviour:
- Address split: offset = low log2(LINE_WORDS) bits; index = next log2(NUM_LINES) bits; tag = remaining bits. Default split is tag 4 / index 2 / offset 2.
- Storage per line: valid bit, tag, LINE_WORDS data words.
- Lookup is combinational. hit = IDLE state and valid[index] and tag match.
- pm_data = the hit word, otherwise 0.
- Reset (reset=0 at a clock edge):
  - clear all valid bits and go to IDLE.
  - Registered outputs clear: mem_rd=0, mem_addr=0, hold_count=0.
  - While reset is held, hold, start_hold and end_hold are forced to 0.
- FSM IDLE:
  - On hit: hold=0, stay in IDLE.
  - On miss: hold=1 and start_hold=1 in the same cycle. Latch line base = pm_address with offset zeroed. Next state is FILL with mem_rd=1, mem_addr=base, hold_count=0.
- FSM FILL:
  - hold=1 every cycle.
  - Each cycle with mem_valid=1: write mem_data to word hold_count of the line, then increment hold_count and mem_addr.
  - On the cycle that writes word LINE_WORDS-1: end_hold=1. Next edge sets valid and tag, mem_rd=0, hold_count=0, state returns to IDLE.
  - mem_valid=0 inserts wait cycles; mem_rd and mem_addr hold their values.
- Miss latency with mem_valid=1 every FILL cycle: hold is high for LINE_WORDS+1 cycles. The next cycle is a hit.
- The line's valid bit stays 0 during the fill. pm_address changes during FILL are ignored; the fill uses the latched base. After the fill, the lookup uses the current pm_address and may miss again.
- mem_valid in IDLE is ignored.
- Conflict miss: a new fill overwrites the old line; its valid bit is cleared at fill start.
- Reset mid-fill aborts the fill: the line stays invalid and mem_rd=0 on the next cycle.
- hold_count saturates at 7 if LINE_WORDS > 8. The default never reaches the limit.

Optional Feature:
PM_CACHE_STATS_EN
- When defined: adds output ports hit_count[15:0] and miss_count[15:0].
  - hit_count increments once per IDLE cycle with hit=1.
  - miss_count increments once per start_hold pulse.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and counters are absent, with no change in behaviour.

Test Plan:
1. Release reset; pm_address=8'h00; memory returns data=addr+8'h10 with mem_valid=mem_rd → start_hold at cycle 0; mem_addr 00,01,02,03; hold_count 0,0,1,2,3; end_hold at cycle 4; cycle 5 hold=0, pm_data=8'h10.
2. After test 1, pm_address 8'h01..8'h03 → hold=0 each cycle; pm_data 8'h11, 8'h12, 8'h13; mem_rd stays 0.
3. pm_address=8'h05 (index 1) fills, then pm_address=8'h00 → hit with no hold; line 0 is retained.
4. pm_address=8'h40 (index 0, tag 4) → conflict miss and refill from 8'h40; then 8'h00 misses again.
5. mem_valid toggles 1,0,0,1,1,0,1 during a fill → mem_addr advances only on valid cycles; hold stays high for 8 cycles; data is correct afterwards.
6. reset=0 at the second FILL cycle → next cycle mem_rd=0, hold=0. After release, the same address misses again (line not valid).

Source files
------------

// File: rtl/pm_line_cache.sv
// Direct-mapped instruction line cache between the core fetch port and slow program memory.
// Optional feature macro: PM_CACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module pm_line_cache #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pm_address,
  output logic [DATA_W-1:0] pm_data,
  output logic              hold,
  output logic              start_hold,
  output logic              end_hold,
  output logic [2:0]        hold_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid
`ifdef PM_CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int IDX_W    = (IDX_BITS == 0) ? 1 : IDX_BITS;
  localparam int TAG_W    = ADDR_W - OFF_W - IDX_BITS;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_next;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags  [NUM_LINES];
  logic [DATA_W-1:0]    words [NUM_LINES][LINE_WORDS];

  function automatic logic [IDX_W-1:0] line_index(input logic [ADDR_W-1:0] a);
    return IDX_W'((a >> OFF_W) & ADDR_W'(NUM_LINES - 1));
  endfunction

  function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (OFF_W + IDX_BITS));
  endfunction

  logic [IDX_W-1:0] index, fill_index;
  logic [TAG_W-1:0] tag, fill_tag;
  logic [OFF_W-1:0] offset, fill_off;
  logic             hit, fill_beat, last_beat;

  assign index  = line_index(pm_address);
  assign tag    = line_tag(pm_address);
  assign offset = pm_address[OFF_W-1:0];

  // The fill position lives entirely in mem_addr: the base is line-aligned, so its low bits are the word.
  assign fill_index = line_index(mem_addr);
  assign fill_tag   = line_tag(mem_addr);
  assign fill_off   = mem_addr[OFF_W-1:0];

  assign hit       = (state == IDLE) && valid[index] && (tags[index] == tag);
  assign pm_data   = hit ? words[index][offset] : '0;
  assign fill_beat = (state == FILL) && mem_valid;
  assign last_beat = fill_beat && (fill_off == LAST_OFF);

  always_comb begin
    state_next = state;
    hold       = 1'b0;
    start_hold = 1'b0;
    end_hold   = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (!hit) begin
            hold       = 1'b1;
            start_hold = 1'b1;
            state_next = FILL;
          end
        end
        FILL: begin
          hold = 1'b1;
          if (last_beat) begin
            end_hold   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // The victim line is invalidated at fill start so a half-written line can never hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid      <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      hold_count <= '0;
    end else if (start_hold) begin
      valid[index] <= 1'b0;
      mem_rd       <= 1'b1;
      mem_addr     <= {pm_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      hold_count   <= '0;
    end else if (fill_beat) begin
      mem_addr <= mem_addr + ADDR_W'(1);
      if (last_beat) begin
        valid[fill_index] <= 1'b1;
        mem_rd            <= 1'b0;
        hold_count        <= '0;
      end else if (hold_count != 3'd7) begin
        hold_count <= hold_count + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && fill_beat) begin
      words[fill_index][fill_off] <= mem_data;
      if (last_beat) tags[fill_index] <= fill_tag;
    end
  end

`ifdef PM_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != 16'hFFFF)         hit_count  <= hit_count + 16'd1;
      if (start_hold && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pm_line_cache.sv
// Self-checking bench for pm_line_cache: directed vector tables, hand-written miss and reset
// sequences, and random fetches checked against a line-level cache model.
module tb_pm_line_cache;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pm_address = 8'h00;
  logic [7:0] pm_data;
  logic       hold, start_hold, end_hold;
  logic [2:0] hold_count;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       mem_valid;
  logic       valid_en = 1'b0;
`ifdef PM_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  logic [7:0] prog [256];

  // Cache model: which line is resident at each index, and the words it was filled with.
  logic       m_valid [4];
  logic [3:0] m_tag   [4];
  logic [7:0] m_data  [4][4];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] addr;
    logic       exp_hold;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs [5];

  pm_line_cache dut (
    .clk        (clk),
    .reset      (reset),
    .pm_address (pm_address),
    .pm_data    (pm_data),
    .hold       (hold),
    .start_hold (start_hold),
    .end_hold   (end_hold),
    .hold_count (hold_count),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid)
`ifdef PM_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  assign mem_valid = mem_rd & valid_en;
  assign mem_data  = prog[mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] a);
    @(posedge clk); #1;
    reset      = 1'b1;
    pm_address = a;
    valid_en   = 1'($urandom_range(0, 1));
    #4;
  endtask

  function automatic logic model_hit(input logic [7:0] a);
    return m_valid[a[3:2]] && (m_tag[a[3:2]] == a[7:4]);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset    = 1'b0;
    valid_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #5;
    clear_model();
  endtask

  task automatic check_hit(input logic [7:0] a);
    applyStimulus(a);
    checkOutput("hit_hold", hold, 1'b0);
    checkOutput("hit_start_hold", start_hold, 1'b0);
    checkOutput("hit_mem_rd", mem_rd, 1'b0);
    checkOutput("hit_data", pm_data, m_data[a[3:2]][a[1:0]]);
  endtask

  // mode 0: memory always ready; mode 1: fixed 1,0,0,1,1,0,1 valid pattern;
  // mode 2: random valid and a wandering pm_address during the fill.
  task automatic run_miss(input logic [7:0] a, input int mode);
    int         beats, cyc, hold_cycles;
    logic [7:0] base, ad;
    logic [6:0] pat;
    pat  = 7'b1011001;
    base = a & 8'hFC;
    @(posedge clk); #1;
    reset      = 1'b1;
    pm_address = a;
    valid_en   = 1'b0;
    #4;
    checkOutput("miss_start_hold", start_hold, 1'b1);
    checkOutput("miss_hold_count", hold_count, 3'd0);
    checkOutput("miss_mem_rd", mem_rd, 1'b0);
    m_valid[a[3:2]] = 1'b0;
    hold_cycles = hold ? 1 : 0;
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 64) begin
      @(posedge clk); #1;
      if (mode == 0)      valid_en = 1'b1;
      else if (mode == 1) valid_en = (cyc < 7) ? pat[cyc] : 1'b1;
      else begin
        valid_en   = 1'($urandom_range(0, 1));
        pm_address = 8'($urandom);
      end
      #4;
      if (hold) hold_cycles++;
      checkOutput("fill_hold", hold, 1'b1);
      checkOutput("fill_mem_rd", mem_rd, 1'b1);
      checkOutput("fill_mem_addr", mem_addr, base + 8'(beats));
      checkOutput("fill_hold_count", hold_count, 3'(beats));
      checkOutput("fill_end_hold", end_hold, valid_en && beats == 3);
      if (valid_en) beats++;
      cyc++;
    end
    if (beats < 4) checkOutput("fill_timeout", beats, 4);
    if (mode == 0) checkOutput("hold_cycles", hold_cycles, 5);
    if (mode == 1) checkOutput("hold_cycles", hold_cycles, 8);
    for (int k = 0; k < 4; k++) begin
      ad = base + 8'(k);
      m_data[a[3:2]][k] = prog[ad];
    end
    m_tag[a[3:2]]   = a[7:4];
    m_valid[a[3:2]] = 1'b1;
    @(posedge clk); #1;
    pm_address = a;
    valid_en   = 1'b0;
    #4;
    checkOutput("post_fill_hold", hold, 1'b0);
    checkOutput("post_fill_mem_rd", mem_rd, 1'b0);
    checkOutput("post_fill_data", pm_data, m_data[a[3:2]][a[1:0]]);
  endtask

  initial begin
    logic [7:0] ra;
    for (int i = 0; i < 256; i++) prog[i] = 8'(i + 16);
    clear_model();
    vecs[0] = '{8'h01, 1'b0, 8'h11};
    vecs[1] = '{8'h02, 1'b0, 8'h12};
    vecs[2] = '{8'h03, 1'b0, 8'h13};
    vecs[3] = '{8'h00, 1'b0, 8'h10};
    vecs[4] = '{8'h07, 1'b0, 8'h17};

    do_reset();
    checkOutput("rst_hold", hold, 1'b0);
    checkOutput("rst_start_hold", start_hold, 1'b0);
    checkOutput("rst_end_hold", end_hold, 1'b0);
    checkOutput("rst_mem_rd", mem_rd, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 8'h00);
    checkOutput("rst_hold_count", hold_count, 3'd0);
    checkOutput("rst_pm_data", pm_data, 8'h00);

    run_miss(8'h00, 0);
    checkOutput("t1_data", pm_data, 8'h10);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i].addr);
      checkOutput("vec_hold", hold, vecs[i].exp_hold);
      checkOutput("vec_data", pm_data, vecs[i].exp_data);
      checkOutput("vec_mem_rd", mem_rd, 1'b0);
    end

    run_miss(8'h05, 0);
    for (int i = 3; i < 5; i++) begin
      applyStimulus(vecs[i].addr);
      checkOutput("vec_hold", hold, vecs[i].exp_hold);
      checkOutput("vec_data", pm_data, vecs[i].exp_data);
      checkOutput("vec_mem_rd", mem_rd, 1'b0);
    end

    run_miss(8'h40, 0);
    checkOutput("conflict_data", pm_data, 8'h50);
    run_miss(8'h00, 0);

    run_miss(8'h09, 1);
    checkOutput("wait_fill_data", pm_data, 8'h19);

    @(posedge clk); #1;
    pm_address = 8'h80;
    valid_en   = 1'b1;
    #4;
    checkOutput("abort_start_hold", start_hold, 1'b1);
    @(posedge clk); #5;
    checkOutput("abort_fill_rd", mem_rd, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    #4;
    checkOutput("abort_hold_in_reset", hold, 1'b0);
    checkOutput("abort_end_hold", end_hold, 1'b0);
    @(posedge clk); #5;
    checkOutput("abort_mem_rd", mem_rd, 1'b0);
    checkOutput("abort_hold", hold, 1'b0);
    checkOutput("abort_hold_count", hold_count, 3'd0);
    clear_model();
    run_miss(8'h80, 0);

    do_reset();
    for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
    for (int n = 0; n < 80; n++) begin
      ra = 8'($urandom_range(0, 31)) | (8'($urandom_range(0, 1)) << 7);
      if (model_hit(ra)) check_hit(ra);
      else               run_miss(ra, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
